// File: rtl/fp_iter_adder.sv
// Multi-cycle IEEE-754 single-precision adder: align, add, one-bit-per-cycle
// normalise, round, with valid/ready handshakes on both sides.
module fp_iter_adder #(
  parameter int unsigned GRS_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  round_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        error,
  output logic        overflow
);
  localparam int unsigned MW = 24 + GRS_BITS;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, OUT} state_t;
  state_t state, state_nx;

  logic [31:0]   a_r, b_r;
  logic [1:0]    mode_r;
  logic          sign_r, sub_r;
  logic [8:0]    exp_r;
  logic [MW-1:0] big_r, small_r;
  logic [MW:0]   sum_r;
  logic [31:0]   result_r;
  logic          error_r, overflow_r;

  logic a_nan, b_nan, a_inf, b_inf, sp_nan, sp_inf;
  always_comb begin
    a_nan  = (&a[30:23]) & (|a[22:0]);
    b_nan  = (&b[30:23]) & (|b[22:0]);
    a_inf  = (&a[30:23]) & ~(|a[22:0]);
    b_inf  = (&b[30:23]) & ~(|b[22:0]);
    sp_nan = a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31]));
    sp_inf = (a_inf | b_inf) & ~sp_nan;
  end

  logic [7:0]    exp_a, exp_b, e_big, e_small, diff;
  logic [MW-1:0] man_a, man_b, m_big, m_small, m_shift, m_lost, m_aligned;
  logic          a_big, sign_big;
  always_comb begin
    exp_a    = a_r[30:23];
    exp_b    = b_r[30:23];
    // E=0 operands (zeros and denormals) get no hidden bit and no fraction
    man_a    = (exp_a != '0) ? {1'b1, a_r[22:0], {GRS_BITS{1'b0}}} : '0;
    man_b    = (exp_b != '0) ? {1'b1, b_r[22:0], {GRS_BITS{1'b0}}} : '0;
    a_big    = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a >= man_b));
    e_big    = a_big ? exp_a : exp_b;
    e_small  = a_big ? exp_b : exp_a;
    m_big    = a_big ? man_a : man_b;
    m_small  = a_big ? man_b : man_a;
    sign_big = a_big ? a_r[31] : b_r[31];
    diff     = e_big - e_small;
    m_shift  = m_small >> diff;
    m_lost   = m_small & ~({MW{1'b1}} << diff);
    if (32'(diff) >= MW) m_aligned = {{(MW-1){1'b0}}, |m_small};
    else                 m_aligned = m_shift | {{(MW-1){1'b0}}, |m_lost};
  end

  logic        g_bit, r_bit, s_bit, lsb, inc, to_inf, zero_neg;
  logic [24:0] rnd;
  logic [8:0]  rexp;
  logic [22:0] rfrac;
  always_comb begin
    lsb   = sum_r[GRS_BITS];
    g_bit = sum_r[GRS_BITS-1];
    r_bit = sum_r[GRS_BITS-2];
    s_bit = |sum_r[GRS_BITS-3:0];
    case (mode_r)
      2'b00:   inc = ~sign_r & (g_bit | r_bit | s_bit);
      2'b01:   inc = sign_r & (g_bit | r_bit | s_bit);
      2'b10:   inc = g_bit & (r_bit | s_bit | lsb);
      default: inc = 1'b0;
    endcase
    rnd      = {1'b0, sum_r[MW-1:GRS_BITS]} + 25'(inc);
    rexp     = exp_r + 9'(rnd[24]);
    rfrac    = rnd[24] ? rnd[23:1] : rnd[22:0];
    to_inf   = (mode_r == 2'b10) | ((mode_r == 2'b00) & ~sign_r) | ((mode_r == 2'b01) & sign_r);
    zero_neg = (mode_r == 2'b01) |
               (a_r[31] & (a_r[30:23] == '0) & b_r[31] & (b_r[30:23] == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (in_valid) state_nx = (sp_nan | sp_inf) ? OUT : ALIGN;
      ALIGN: state_nx = ADD;
      ADD:   state_nx = NORM;
      NORM: begin
        if (sum_r == '0)                    state_nx = OUT;
        else if (sum_r[MW] | sum_r[MW-1])   state_nx = ROUND;
        else if (exp_r == 9'd1)             state_nx = OUT;
      end
      ROUND: state_nx = OUT;
      OUT:   if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
    result    = result_r;
    error     = error_r;
    overflow  = overflow_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      mode_r     <= '0;
      sign_r     <= 1'b0;
      sub_r      <= 1'b0;
      exp_r      <= '0;
      big_r      <= '0;
      small_r    <= '0;
      sum_r      <= '0;
      result_r   <= '0;
      error_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r        <= a;
          b_r        <= b;
          mode_r     <= round_mode;
          error_r    <= 1'b0;
          overflow_r <= 1'b0;
          if (sp_nan) begin
            result_r <= 32'h7FC0_0000;
            error_r  <= 1'b1;
          end else if (sp_inf) begin
            result_r   <= a_inf ? a : b;
            overflow_r <= 1'b1;
          end
        end
        ALIGN: begin
          sign_r  <= sign_big;
          sub_r   <= a_r[31] ^ b_r[31];
          exp_r   <= {1'b0, e_big};
          big_r   <= m_big;
          small_r <= m_aligned;
        end
        ADD: sum_r <= sub_r ? ({1'b0, big_r} - {1'b0, small_r})
                            : ({1'b0, big_r} + {1'b0, small_r});
        NORM: begin
          if (sum_r == '0) begin
            result_r <= {zero_neg, 31'h0};
          end else if (sum_r[MW]) begin
            sum_r <= {1'b0, sum_r[MW:2], sum_r[1] | sum_r[0]};
            exp_r <= exp_r + 9'd1;
          end else if (!sum_r[MW-1]) begin
            if (exp_r == 9'd1) begin
              result_r <= {sign_r, 31'h0};
            end else begin
              sum_r <= sum_r << 1;
              exp_r <= exp_r - 9'd1;
            end
          end
        end
        ROUND: begin
          if (rexp >= 9'd255) begin
            overflow_r <= 1'b1;
            result_r   <= to_inf ? {sign_r, 8'hFF, 23'h0} : {sign_r, 31'h7F7F_FFFF};
          end else begin
            result_r <= {sign_r, rexp[7:0], rfrac};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/fp_iter_adder.md
Name: fp_iter_adder

Overview:
Multi-cycle IEEE-754 single-precision adder (A + B). It is the additive counterpart of the FPU's pipelined subtractor and shares its flag semantics and round_mode port. Operands enter through a valid/ready handshake. An FSM aligns, adds, normalises one bit per cycle, and rounds. The result is held under a valid/ready output handshake, so the block can sit behind an operand FIFO or a result mux.

Parameters:
GRS_BITS, 3, extra low-order bits (guard, round, sticky) carried through align, add and normalise.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands; equals (state==IDLE)
a  in  32  operand A, IEEE-754 single
b  in  32  operand B, IEEE-754 single
round_mode  in  2  00 toward +inf, 01 toward -inf, 10 nearest-even, 11 toward zero
out_valid  out  1  result, error and overflow valid
out_ready  in  1  consumer takes result
result  out  32  A+B
error  out  1  result is NaN (invalid operation or NaN input)
overflow  out  1  result is infinite, or saturated to max finite because of exponent overflow

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset state: state=IDLE, out_valid=0, result=0, error=0, overflow=0, so in_ready=1. Reset mid-operation discards the in-flight operation with no output.
- Accept: on a clock edge with in_valid && in_ready, register a, b and round_mode. round_mode is not re-sampled during the operation.
- States: IDLE, ALIGN, ADD, NORM, ROUND, OUT.
- IDLE, on accept:
  - NaN input (E=FF, F≠0), or +inf plus -inf: result=0x7FC00000, error=1, go to OUT.
  - One or both operands inf with the same sign: result is that inf, overflow=1, go to OUT.
  - Otherwise go to ALIGN.
- Denormals: any input with E=0 is treated as a signed zero (flush).
- ALIGN: form mantissas {hidden, F, GRS}, with hidden=1 when E≠0. Shift the smaller-exponent mantissa right by the exponent difference, OR-ing shifted-out bits into sticky. If the difference is ≥ 27, that mantissa becomes sticky-only. Working exponent = larger E.
- ADD: equal signs → add magnitudes, 28-bit result with carry. Different signs → larger magnitude minus smaller, sign taken from the larger. Magnitude equality compares both exponent and mantissa.
- NORM, one action per cycle:
  - Sum = 0: result = signed zero, go to OUT. The zero is +0, except -0 when both operands are -0 or when round_mode=01.
  - Carry set: shift right 1 with sticky OR, exp+1, go to ROUND.
  - Hidden bit set: go to ROUND.
  - Otherwise: if exp==1, flush to signed zero and go to OUT; else shift left 1, exp-1, stay in NORM.
- ROUND: increment decision per mode uses G, R, S and the sign.
  - Nearest-even: increment when G && (R|S|lsb).
  - +inf: increment when sign=0 and G|R|S.
  - -inf: increment when sign=1 and G|R|S.
  - Toward zero: never increment.
  - A mantissa carry-out from rounding → shift right, exp+1.
  - Exp ≥ 255: overflow=1. Result is inf for nearest, and for the directed mode toward the result's sign. Otherwise result is max finite 0x7F7FFFFF with that sign.
  - Go to OUT.
- OUT: out_valid=1; result, error and overflow are held stable until out_valid && out_ready. On that edge go to IDLE and drop out_valid. in_ready stays 0 through OUT, so there is no accept on the same edge.
- Latency, in edges from accept to out_valid high:
  - Special case: 1.
  - Zero sum: 4.
  - Normal: 5 + k, where k is the number of left shifts in NORM. k ≤ 26.

Test Plan:
- 0x3F800000 + 0x40000000, mode 10 → result 0x40400000, error=0, overflow=0; out_valid on the 5th edge after accept.
- 0x3F800000 + 0xBF7FFFFF, mode 10 → result 0x33800000, k=24, out_valid on the 29th edge; in_ready=0 throughout.
- 0x7F7FFFFF + 0x7F7FFFFF → mode 10: 0x7F800000, overflow=1; mode 11: 0x7F7FFFFF, overflow=1; mode 01: 0x7F7FFFFF, overflow=1.
- 0x7F800000 + 0xFF800000 → 0x7FC00000, error=1, out_valid 1 edge after accept. Also 0x7FC00001 + 0x3F800000 → 0x7FC00000, error=1.
- Rounding, 0x3F800000 + 0x33800000 (tie) → mode 10: 0x3F800000; mode 00: 0x3F800001; mode 11: 0x3F800000. Also 0x3F800000 + 0x33C00000, mode 10 → 0x3F800001.
- Handshake and reset:
  - Hold out_ready=0 for 3 cycles in OUT → result and flags stable, in_valid ignored.
  - 0x3F800000 + 0xBF800000, mode 01 → 0x80000000.
  - Pull rst_n low mid-NORM → out_valid=0 and in_ready=1 immediately; the next operation completes correctly.
